// File: rtl/pixel_pair_sync.sv
// Pairs ColorTransform pixels with Homography results via a small FIFO.
// Optional mismatch counter is built only when SYNC_MIS_CNT_EN is defined.
module pixel_pair_sync #(
  parameter int CW         = 10,
  parameter int DEPTH      = 4,
  parameter int MIS_POLICY = 0
) (
  input  logic                     clk_25,
  input  logic                     rst_n,
  input  logic [2*CW+23:0]         q,
  input  logic                     rdreq,
  input  logic [CW-1:0]            return_x,
  input  logic [CW-1:0]            return_y,
  input  logic [4:0]               r,
  input  logic [5:0]               g,
  input  logic [4:0]               b,
  input  logic                     ready,
  input  logic                     clr,
  output logic                     val,
  output logic [CW-1:0]            sync_x,
  output logic [CW-1:0]            sync_y,
  output logic [4:0]               dvi_r,
  output logic [5:0]               dvi_g,
  output logic [4:0]               dvi_b,
  output logic [4:0]               ccd_r,
  output logic [5:0]               ccd_g,
  output logic [4:0]               ccd_b,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     mismatch,
  output logic                     resync,
  output logic [15:0]              mis_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [4:0]    r;
    logic [5:0]    g;
    logic [4:0]    b;
  } entry_t;

  typedef enum logic [1:0] {RUN, RESYNC, WAIT_HOMO} state_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  state_t        state_q, state_d;
  logic          val_q, val_d;
  entry_t        out_q, out_d;
  logic [4:0]    ccd_r_q, ccd_r_d;
  logic [5:0]    ccd_g_q, ccd_g_d;
  logic [4:0]    ccd_b_q, ccd_b_d;
  logic          ovf_q, ovf_d;
  logic          und_q, und_d;
  logic          mis_q, mis_d;

  entry_t wr_entry, head;
  logic   q_zero, ret_zero;
  logic   wr_req, rd_req, empty, full;
  logic   push, pop, mis_pop, flush;

  logic unused_q_bits;
  assign unused_q_bits = ^{q[18:16], q[9:8], q[2:0]};

  always_comb begin
    wr_entry.x = q[2*CW+23 -: CW];
    wr_entry.y = q[CW+23 -: CW];
    wr_entry.r = q[23:19];
    wr_entry.g = q[15:10];
    wr_entry.b = q[7:3];
    head       = mem_q[rd_ptr_q];
    q_zero     = (wr_entry.x == '0) && (wr_entry.y == '0);
    ret_zero   = (return_x == '0) && (return_y == '0);
    empty      = (level_q == '0);
    full       = (level_q == LW'(DEPTH));
    wr_req     = 1'b0;
    rd_req     = 1'b0;
    unique case (state_q)
      RUN: begin
        wr_req = rdreq;
        rd_req = ready;
      end
      RESYNC: begin
        wr_req = rdreq && q_zero;
      end
      WAIT_HOMO: begin
        wr_req = rdreq;
        rd_req = ready && ret_zero;
      end
      default: ;
    endcase
    pop     = rd_req && !empty;
    push    = wr_req && (!full || pop);
    mis_pop = pop && ((head.x != return_x) || (head.y != return_y));
    flush   = (MIS_POLICY == 1) && (state_q == RUN) && mis_pop;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LW'(push) - LW'(pop);
    // A realign discards everything still queued, including a same-cycle write
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
    state_d = state_q;
    if (MIS_POLICY == 1) begin
      unique case (state_q)
        RUN:       if (flush) state_d = RESYNC;
        RESYNC:    if (push) state_d = WAIT_HOMO;
        WAIT_HOMO: if (pop) state_d = RUN;
        default:   state_d = RUN;
      endcase
    end
    val_d   = pop;
    out_d   = pop ? head : out_q;
    ccd_r_d = pop ? r : ccd_r_q;
    ccd_g_d = pop ? g : ccd_g_q;
    ccd_b_d = pop ? b : ccd_b_q;
    ovf_d   = clr ? 1'b0 : ovf_q | (wr_req && full && !pop);
    und_d   = clr ? 1'b0 : und_q | (rd_req && empty);
    mis_d   = clr ? 1'b0 : mis_q | mis_pop;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      state_q  <= RUN;
      val_q    <= 1'b0;
      out_q    <= '0;
      ccd_r_q  <= '0;
      ccd_g_q  <= '0;
      ccd_b_q  <= '0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      state_q  <= state_d;
      val_q    <= val_d;
      out_q    <= out_d;
      ccd_r_q  <= ccd_r_d;
      ccd_g_q  <= ccd_g_d;
      ccd_b_q  <= ccd_b_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
      mis_q    <= mis_d;
    end
  end

`ifdef SYNC_MIS_CNT_EN
  logic [15:0] mis_cnt_q, mis_cnt_d;

  always_comb begin
    mis_cnt_d = mis_cnt_q;
    if (clr) mis_cnt_d = '0;
    else if (mis_pop && (mis_cnt_q != 16'hFFFF)) mis_cnt_d = mis_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) mis_cnt_q <= '0;
    else mis_cnt_q <= mis_cnt_d;
  end

  assign mis_cnt = mis_cnt_q;
`else
  assign mis_cnt = '0;
`endif

  assign val       = val_q;
  assign sync_x    = out_q.x;
  assign sync_y    = out_q.y;
  assign dvi_r     = out_q.r;
  assign dvi_g     = out_q.g;
  assign dvi_b     = out_q.b;
  assign ccd_r     = ccd_r_q;
  assign ccd_g     = ccd_g_q;
  assign ccd_b     = ccd_b_q;
  assign level     = level_q;
  assign overflow  = ovf_q;
  assign underflow = und_q;
  assign mismatch  = mis_q;
  assign resync    = (state_q != RUN);

endmodule
